stall_sequencer: RTL

Pipeline stall/flush sequencer that consumes the hazard requests raised in ID by the hazard detection unit and drives the enable and bubble controls of the PC, IF/ID and ID/EX registers. It owns the stall duration, so a branch that depends on a load gets its required second stall cycle. It also applies the IF/ID flush for taken branches resolved in ID, and keeps a saturating stall-cycle performance counter. It sits between the hazard detection unit and the PC / pipeline-register write-enable inputs.

---
 rtl/stall_sequencer.sv | 78 +++++++
 1 files changed

// File: rtl/stall_sequencer.sv
// rtl/stall_sequencer.sv - stall/flush sequencer for PC, IF/ID and ID/EX controls
// Turns ID-stage hazard requests into stall/bubble/flush strobes and counts stall cycles.
module stall_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             haz_load_use,
  input  logic             haz_br_alu,
  input  logic             haz_br_load,
  input  logic             branch_taken,
  output logic             PCwrite,
  output logic             IF_IDwrite,
  output logic             IF_IDflush,
  output logic             ID_EXbubble,
  output logic             stalled,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e           st_q, st_d;
  logic             rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req;
  logic             stall_c;

  assign req = haz_load_use | haz_br_alu | haz_br_load;

  // Reset gates the stall so the pipeline runs freely while reset is held.
  assign stall_c = ~reset & ((st_q == HOLD) | req);

  always_comb begin
    PCwrite     = ~stall_c;
    IF_IDwrite  = ~stall_c;
    ID_EXbubble = stall_c;
    stalled     = stall_c;
    IF_IDflush  = ~reset & ~stall_c & branch_taken;
  end

  always_comb begin
    st_d  = st_q;
    rem_d = rem_q;
    if (st_q == HOLD) begin
      if (rem_q) begin
        st_d  = HOLD;
        rem_d = 1'b0;
      end else begin
        st_d  = RUN;
      end
    end else if (haz_br_load) begin
      // Branch on a load result owes one more cycle after this request cycle.
      st_d  = HOLD;
      rem_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= RUN;
      rem_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule
